// File: rtl/comparators_pkg.sv
// Shared constants for the signed comparator pair and its ripple subtractor.
package comparators_pkg;
    localparam int COMP_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/comparators_if.sv
// Operand/result bundle for the comparator pair.
// The comparator drives the slave side and the requester drives the master side.
interface comparators_if
    import comparators_pkg::*;
#(
    parameter int N = COMP_WIDTH_DEFAULT
) ();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         equals;
    logic         less_than;
    logic [N-2:0] sum;
    logic         first_comp;
    logic         equals_q;
    logic         less_than_q;

    modport master (
        output a, b,
        input  equals, less_than, sum, first_comp, equals_q, less_than_q
    );

    modport slave (
        input  a, b,
        output equals, less_than, sum, first_comp, equals_q, less_than_q
    );
endinterface

// File: rtl/comparators_adder_n.sv
// Gate-level ripple-carry adder built from N full adders.
// In the comparator it is used as a subtractor: the caller inverts b and sets c_in to 1.
module adder_n
    import comparators_pkg::*;
#(
    parameter int N = COMP_WIDTH_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry;

    assign carry[0] = c_in;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            logic p;
            assign p            = a[gi] ^ b[gi];
            assign sum[gi]      = p ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & p);
        end
    endgenerate

    assign c_out = carry[N];
endmodule

// File: rtl/comparators.sv
// Signed N-bit == and < comparator with a combinational datapath and registered copies.
// Equality uses an XNOR-reduce; less-than uses a sign split plus an (N-1)-bit ripple subtract.
module comparators
    import comparators_pkg::*;
#(
    parameter int N = COMP_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    comparators_if.slave  bus
);
    logic [N-1:0] eq_bits;
    logic         equals_c;
    logic [N-2:0] b_low_inv;
    logic [N-2:0] diff;
    logic         carry_out;
    logic         sign_diff;
    logic         less_than_c;
    logic         eq_d;
    logic         eq_q;
    logic         lt_d;
    logic         lt_q;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_eq
            assign eq_bits[gi] = bus.a[gi] ~^ bus.b[gi];
        end
    endgenerate

    assign equals_c  = &eq_bits;
    assign b_low_inv = ~bus.b[N-2:0];

    // a_low + ~b_low + 1: carry out is the inverse of the borrow.
    adder_n #(
        .N (N - 1)
    ) u_sub (
        .a     (bus.a[N-2:0]),
        .b     (b_low_inv),
        .c_in  (1'b1),
        .sum   (diff),
        .c_out (carry_out)
    );

    // Differing signs: the negative operand is the smaller one.
    assign sign_diff   = bus.a[N-1] ^ bus.b[N-1];
    assign less_than_c = sign_diff ? bus.a[N-1] : ~carry_out;

    assign eq_d = equals_c;
    assign lt_d = less_than_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            lt_q <= lt_d;
        end
    end

    assign bus.equals      = equals_c;
    assign bus.less_than   = less_than_c;
    assign bus.sum         = diff;
    assign bus.first_comp  = sign_diff;
    assign bus.equals_q    = eq_q;
    assign bus.less_than_q = lt_q;
endmodule

// File: tb/tb_comparators.sv
// Directed and random checks of the comparator pair: combinational outputs and registered copies.
module tb_comparators;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    comparators_if #(.N(N)) bus ();

    comparators #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge and sample 1 ns later, away from posedge.
    task automatic apply(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        #1;
        $display("vec a=%08h b=%08h eq=%0b lt=%0b sum=%08h fc=%0b",
                 av, bv, bus.equals, bus.less_than, bus.sum, bus.first_comp);
    endtask

    task automatic check_comb(input string tag, input logic exp_eq, input logic exp_lt,
                              input logic [N-2:0] exp_sum, input logic exp_fc);
        check({tag, ".eq"},  {63'd0, bus.equals},     {63'd0, exp_eq});
        check({tag, ".lt"},  {63'd0, bus.less_than},  {63'd0, exp_lt});
        check({tag, ".sum"}, {33'd0, bus.sum},        {33'd0, exp_sum});
        check({tag, ".fc"},  {63'd0, bus.first_comp}, {63'd0, exp_fc});
    endtask

    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         m_eq;
    logic         m_lt;
    logic [N-2:0] m_sum;
    logic [N-1:0] big;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.a    = '0;
        bus.b    = '0;

        // Hand-computed directed vectors
        apply(32'd0, 32'd0);
        check_comb("zero", 1'b1, 1'b0, 31'd0, 1'b0);
        apply(32'hFFFFFFFF, 32'd1);
        check_comb("m1_vs_1", 1'b0, 1'b1, 31'h7FFFFFFE, 1'b1);
        apply(32'd38273, 32'd38273);
        check_comb("eq38273", 1'b1, 1'b0, 31'd0, 1'b0);
        apply(32'd1000, 32'd38273);
        check_comb("1000_lt", 1'b0, 1'b1, 31'h7FFF6E67, 1'b0);
        apply(32'd38273, 32'd1000);
        check_comb("1000_sw", 1'b0, 1'b0, 31'd37273, 1'b0);
        big = 32'd1710417496;
        apply(32'd574982, big);
        check("big_lt.lt", {63'd0, bus.less_than}, 64'd1);
        check("big_lt.eq", {63'd0, bus.equals}, 64'd0);
        apply(big, 32'd574982);
        check_comb("big_sw", 1'b0, 1'b0, 31'd1709842514, 1'b0);
        apply(32'h80000000, 32'h7FFFFFFF);
        check_comb("min_max", 1'b0, 1'b1, 31'd1, 1'b1);
        apply(32'h7FFFFFFF, 32'h80000000);
        check_comb("max_min", 1'b0, 1'b0, 31'h7FFFFFFF, 1'b1);
        apply(32'hFFFFFFFF, 32'd0);
        check_comb("m1_vs_0", 1'b0, 1'b1, 31'h7FFFFFFF, 1'b1);

        // Reset held for 2 cycles with equal operands: registers must stay clear.
        apply(32'd5, 32'd5);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.eq_q", {63'd0, bus.equals_q}, 64'd0);
        check("rst.lt_q", {63'd0, bus.less_than_q}, 64'd0);

        apply(32'd3, 32'd3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel.eq_q", {63'd0, bus.equals_q}, 64'd1);
        check("rel.lt_q", {63'd0, bus.less_than_q}, 64'd0);

        // Reset mid-stream wins over new data on the same edge.
        apply(32'd1, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid.lt_q", {63'd0, bus.less_than_q}, 64'd0);
        check("mid.eq_q", {63'd0, bus.equals_q}, 64'd0);
        check("mid.comb_lt", {63'd0, bus.less_than}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post.lt_q", {63'd0, bus.less_than_q}, 64'd1);

        // Random pairs against a behavioural model.
        for (int i = 0; i < 10; i++) begin
            ra = $random;
            rb = $random;
            if (i == 3) rb = ra;
            m_eq  = (ra == rb);
            m_lt  = ($signed(ra) < $signed(rb));
            m_sum = ra[N-2:0] - rb[N-2:0];
            apply(ra, rb);
            check_comb($sformatf("rnd%0d", i), m_eq, m_lt, m_sum, ra[N-1] ^ rb[N-1]);
            check($sformatf("rnd%0d.excl", i), {63'd0, bus.equals & bus.less_than}, 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d.eq_q", i), {63'd0, bus.equals_q}, {63'd0, m_eq});
            check($sformatf("rnd%0d.lt_q", i), {63'd0, bus.less_than_q}, {63'd0, m_lt});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
